id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The parameter XLEN SHALL default to 32 and set the width of all data and PC ports.
REQ-002 Port clk SHALL be an input of width 1 carrying the single clock; every register SHALL update on its rising edge.
REQ-003 Port rst SHALL be an input of width 1 carrying a synchronous, active-high reset.
REQ-004 The decode-side inputs SHALL be:
- id_valid (1)
- id_pc (XLEN)
- id_rs1_data and id_rs2_data (XLEN each)
- id_imm (XLEN)
- id_rs1_addr, id_rs2_addr and id_rd_addr (5 each)
- id_funct3 (3) and id_funct7_b5 (1)
- id_is_rtype, id_alu_src_imm, id_is_lui, id_is_auipc, id_mem_read and id_reg_write (1 each)
REQ-005 The pipeline-control inputs SHALL be stall (1) to hold the register and flush (1) to insert a bubble.
REQ-006 The forwarding inputs SHALL be:
- exm_reg_write (1), exm_rd (5) and exm_result (XLEN), from the stage one ahead
- wb_reg_write (1), wb_rd (5) and wb_result (XLEN), from the stage two ahead
REQ-007 The ALU-facing outputs SHALL be aluop_control (4), operand1 (XLEN) and operand2 (XLEN).
REQ-008 The pass-down outputs SHALL be:
- ex_valid (1), ex_rd (5), ex_reg_write (1) and ex_mem_read (1)
- ex_store_data (XLEN), the forwarded rs2 value
REQ-009 The output load_use_hazard (1) SHALL be combinational and is consumed by decode and fetch as a stall request.

Function
REQ-010 On each rising edge, the register update SHALL apply this priority: rst > flush > stall > load.
REQ-011 When rst is high, all registered fields SHALL be cleared to zero.
REQ-012 When flush is high, ex_valid, ex_reg_write and ex_mem_read SHALL be cleared; the other fields are don't-care.
REQ-013 When stall is high, every registered field SHALL hold its value.
REQ-014 On load, the register SHALL capture all id_* inputs, with latency of exactly one cycle from decode to ALU operands.
REQ-015 When id_valid is 0 on load, the registered reg_write and mem_read SHALL be forced to 0.
REQ-016 The forwarded rs1 value fwd1 SHALL be selected as follows:
- exm_result if exm_reg_write, exm_rd != 0 and exm_rd == rs1_q
- else wb_result if wb_reg_write, wb_rd != 0 and wb_rd == rs1_q
- else rs1_data_q
REQ-017 The forwarded rs2 value fwd2 SHALL be selected by the same rule as fwd1, applied to rs2_q and rs2_data_q.
REQ-018 When both forwarding sources match the same register, the exm source SHALL win.
REQ-019 A source register address of x0 SHALL never be forwarded.
REQ-020 operand1 SHALL be pc_q if is_auipc_q, else 0 if is_lui_q, else fwd1.
REQ-021 operand2 SHALL be imm_q if alu_src_imm_q, else fwd2.
REQ-022 ex_store_data SHALL always equal fwd2.
REQ-023 aluop_control SHALL be:
- {funct7_b5_q, funct3_q} if is_rtype_q
- {funct7_b5_q, 3'b101} if an I-type ALU instruction has funct3_q == 101 (SRLI/SRAI)
- {1'b0, funct3_q} for any other I-type ALU instruction (ADDI never becomes SUB)
- 4'b0000 (ADD) if is_lui_q or is_auipc_q
REQ-024 aluop_control SHALL take one of the encodings ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-025 load_use_hazard SHALL equal ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1_addr) | (ex_rd == id_rs2_addr)).
REQ-026 While load_use_hazard is high, upstream SHALL hold decode and the top level SHALL drive flush (a bubble) into this stage.
REQ-027 When a hazard cycle also has stall high, flush SHALL take precedence.
REQ-028 The outputs SHALL depend only on registered state and the forwarding inputs; there SHALL be no combinational path from the id_* data inputs to operand1 or operand2.

Reset
REQ-029 After rst, the outputs SHALL be ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_rd=0, aluop_control=0000, operand1=0, operand2=0, ex_store_data=0 and load_use_hazard=0, provided the forwarding inputs are inactive.
REQ-030 An rst asserted mid-stall SHALL discard the held instruction within one cycle.

Structure
REQ-031 The ALU opcode constants (ADD..AND) SHALL live in a shared package, core_pkg, which the ALU also uses.
REQ-032 The packed ID/EX register record type SHALL also live in core_pkg.
REQ-033 The forwarding comparator SHALL be one sub-module, fwd_unit, instantiated twice (once for rs1, once for rs2).

Verification
REQ-034 Test ADD forwarded from exm:
- Stimulus: load an R-type with funct3=000, f7b5=0, rs1=5; drive exm_rd=5, exm_reg_write=1, exm_result=0x10, rs1_data=0x99.
- Required: operand1=0x10 and aluop_control=0000.
REQ-035 Test double match:
- Stimulus: exm_rd=wb_rd=7, both write enables set, exm_result=1, wb_result=2, rs2=7, R-type.
- Required: operand2=1.
REQ-036 Test x0 source:
- Stimulus: rs1=0; drive exm_rd=0, exm_reg_write=1, exm_result=0xFF, rs1_data=0.
- Required: operand1=0.
REQ-037 Test I-type shifts and ADDI:
- SRAI (funct3=101, f7b5=1, alu_src_imm=1, imm=3) -> aluop_control=1101 and operand2=3.
- ADDI with imm bit 30 set (f7b5=1) -> aluop_control=0000.
REQ-038 Test load-use:
- Stimulus: a load with rd=4 in EX while decode presents rs2=4.
- Required: load_use_hazard=1; after flush, ex_valid=0 and ex_reg_write=0, and the stalled instruction then loads with fwd from wb.
REQ-039 Test priority:
- Stimulus: stall=1 with flush=1, then rst=1 with stall=1.
- Required: the first gives a bubble; the second clears all fields on the next edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: ALU opcode encodings and the ID/EX control record.
// Pure declarations, no timing.
// No flow control of its own.
package core_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [2:0] F3_SR    = 3'b101;

    // Control half of the ID/EX pipeline register; data words sit beside it
    // because their width follows the XLEN parameter of the stage.
    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic       funct7_b5;
        logic       is_rtype;
        logic       alu_src_imm;
        logic       is_lui;
        logic       is_auipc;
        logic       mem_read;
        logic       reg_write;
    } id_ex_ctrl_t;

    // For I-type only shifts-right carry funct7 bit 5; elsewhere it is an
    // immediate bit, so ADDI must never turn into SUB.
    function automatic logic [3:0] alu_decode(input id_ex_ctrl_t c);
        logic [3:0] op;
        op = ALU_ADD;
        if (c.is_lui || c.is_auipc)
            op = ALU_ADD;
        else if (c.is_rtype)
            op = {c.funct7_b5, c.funct3};
        else if (c.funct3 == F3_SR)
            op = {c.funct7_b5, F3_SR};
        else
            op = {1'b0, c.funct3};
        return op;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode, forwarding and ALU-facing bundle of the ID/EX stage.
// Wires only, no latency.
// Backpressure is carried by the stage's stall/flush and load_use_hazard.
interface id_ex_stage_if #(
    parameter int XLEN = 32
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rs1_addr;
    logic [4:0]      id_rs2_addr;
    logic [4:0]      id_rd_addr;
    logic [2:0]      id_funct3;
    logic            id_funct7_b5;
    logic            id_is_rtype;
    logic            id_alu_src_imm;
    logic            id_is_lui;
    logic            id_is_auipc;
    logic            id_mem_read;
    logic            id_reg_write;

    logic            exm_reg_write;
    logic [4:0]      exm_rd;
    logic [XLEN-1:0] exm_result;
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_result;

    logic [3:0]      aluop_control;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            ex_valid;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic [XLEN-1:0] ex_store_data;
    logic            load_use_hazard;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_funct3, id_funct7_b5,
               id_is_rtype, id_alu_src_imm, id_is_lui, id_is_auipc,
               id_mem_read, id_reg_write,
               exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result,
        input  aluop_control, operand1, operand2, ex_valid, ex_rd,
               ex_reg_write, ex_mem_read, ex_store_data, load_use_hazard
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_funct3, id_funct7_b5,
               id_is_rtype, id_alu_src_imm, id_is_lui, id_is_auipc,
               id_mem_read, id_reg_write,
               exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result,
        output aluop_control, operand1, operand2, ex_valid, ex_rd,
               ex_reg_write, ex_mem_read, ex_store_data, load_use_hazard
    );
endinterface

// File: rtl/fwd_unit.sv
// Operand bypass select for one source register.
// Combinational, zero latency.
// No flow control; the nearest in-flight producer wins, x0 is never bypassed.
module fwd_unit #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] rs_data,
    input  logic            exm_reg_write,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] fwd
);
    // Younger result (one stage ahead) shadows the older one.
    always_comb begin
        fwd = rs_data;
        if ((rs != 5'd0) && exm_reg_write && (exm_rd == rs))
            fwd = exm_result;
        else if ((rs != 5'd0) && wb_reg_write && (wb_rd == rs))
            fwd = wb_result;
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and ALU opcode decode.
// One cycle from decode inputs to ALU operands.
// stall holds the register; flush or a load-use hazard loads a bubble instead.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    id_ex_stage_if.slave bus
);
    id_ex_ctrl_t     ctrl_q;
    id_ex_ctrl_t     ctrl_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;
    logic            hazard;
    logic            bubble;

    // Gather decode controls; an invalid slot must never write or load.
    always_comb begin
        ctrl_d             = '0;
        ctrl_d.valid       = bus.id_valid;
        ctrl_d.rs1         = bus.id_rs1_addr;
        ctrl_d.rs2         = bus.id_rs2_addr;
        ctrl_d.rd          = bus.id_rd_addr;
        ctrl_d.funct3      = bus.id_funct3;
        ctrl_d.funct7_b5   = bus.id_funct7_b5;
        ctrl_d.is_rtype    = bus.id_is_rtype;
        ctrl_d.alu_src_imm = bus.id_alu_src_imm;
        ctrl_d.is_lui      = bus.id_is_lui;
        ctrl_d.is_auipc    = bus.id_is_auipc;
        ctrl_d.mem_read    = bus.id_mem_read & bus.id_valid;
        ctrl_d.reg_write   = bus.id_reg_write & bus.id_valid;
    end

    // A load in EX whose rd is read by decode cannot be bypassed in time.
    assign hazard = ctrl_q.valid & ctrl_q.mem_read & (ctrl_q.rd != 5'd0)
                  & ((ctrl_q.rd == bus.id_rs1_addr) | (ctrl_q.rd == bus.id_rs2_addr));
    assign bubble = flush | hazard;

    // Pipeline register: reset, then bubble, then hold, then load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else if (bubble) begin
            ctrl_q.valid     <= 1'b0;
            ctrl_q.reg_write <= 1'b0;
            ctrl_q.mem_read  <= 1'b0;
        end else if (!stall) begin
            ctrl_q     <= ctrl_d;
            pc_q       <= bus.id_pc;
            rs1_data_q <= bus.id_rs1_data;
            rs2_data_q <= bus.id_rs2_data;
            imm_q      <= bus.id_imm;
        end
    end

    fwd_unit #(.XLEN(XLEN)) u_fwd1 (
        .rs            (ctrl_q.rs1),
        .rs_data       (rs1_data_q),
        .exm_reg_write (bus.exm_reg_write),
        .exm_rd        (bus.exm_rd),
        .exm_result    (bus.exm_result),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .wb_result     (bus.wb_result),
        .fwd           (fwd1)
    );

    fwd_unit #(.XLEN(XLEN)) u_fwd2 (
        .rs            (ctrl_q.rs2),
        .rs_data       (rs2_data_q),
        .exm_reg_write (bus.exm_reg_write),
        .exm_rd        (bus.exm_rd),
        .exm_result    (bus.exm_result),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .wb_result     (bus.wb_result),
        .fwd           (fwd2)
    );

    assign bus.load_use_hazard = hazard;
    assign bus.ex_valid        = ctrl_q.valid;
    assign bus.ex_rd           = ctrl_q.rd;
    assign bus.ex_reg_write    = ctrl_q.reg_write;
    assign bus.ex_mem_read     = ctrl_q.mem_read;
    assign bus.ex_store_data   = fwd2;
    assign bus.aluop_control   = alu_decode(ctrl_q);
    assign bus.operand1        = ctrl_q.is_auipc ? pc_q
                               : (ctrl_q.is_lui ? '0 : fwd1);
    assign bus.operand2        = ctrl_q.alu_src_imm ? imm_q : fwd2;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vectors, hazard/priority
// sequences, then randomized traffic against a behavioural model.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    logic stall;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    id_ex_stage_if #(.XLEN(32)) bus ();

    id_ex_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rt, si, lui, au;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rs1, rs2;
        logic [31:0] pc, d1, d2, imm;
        logic        ew;
        logic [4:0]  erd;
        logic [31:0] eres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic [3:0]  op;
        logic [31:0] o1, o2, st;
    } vec_t;

    // Instruction as the EX stage should hold it.
    typedef struct packed {
        logic        v, rw, mr;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        f7, rt, si, lui, au;
        logic [31:0] pc, d1, d2, imm;
    } mdl_t;

    vec_t tbl[11];
    mdl_t m;
    mdl_t nx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, rt, si, lui, au, mr, rw,
                            input logic [2:0] f3, input logic f7,
                            input logic [4:0] rs1, rs2, rd,
                            input logic [31:0] pc, d1, d2, imm);
        bus.id_valid       = v;
        bus.id_is_rtype    = rt;
        bus.id_alu_src_imm = si;
        bus.id_is_lui      = lui;
        bus.id_is_auipc    = au;
        bus.id_mem_read    = mr;
        bus.id_reg_write   = rw;
        bus.id_funct3      = f3;
        bus.id_funct7_b5   = f7;
        bus.id_rs1_addr    = rs1;
        bus.id_rs2_addr    = rs2;
        bus.id_rd_addr     = rd;
        bus.id_pc          = pc;
        bus.id_rs1_data    = d1;
        bus.id_rs2_data    = d2;
        bus.id_imm         = imm;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
        bus.exm_reg_write = ew;
        bus.exm_rd        = erd;
        bus.exm_result    = eres;
        bus.wb_reg_write  = ww;
        bus.wb_rd         = wrd;
        bus.wb_result     = wres;
    endtask

    // Most recent architectural value of a source register as seen by EX.
    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] d);
        if (rs == 5'd0) return d;
        if (bus.exm_reg_write && bus.exm_rd == rs) return bus.exm_result;
        if (bus.wb_reg_write && bus.wb_rd == rs) return bus.wb_result;
        return d;
    endfunction

    // Opcode named by the instruction's meaning (only legal encodings generated).
    function automatic logic [3:0] ref_op(input mdl_t x);
        if (x.lui || x.au) return 4'b0000;
        case (x.f3)
            3'd0: return (x.rt && x.f7) ? 4'b1000 : 4'b0000;
            3'd1: return 4'b0001;
            3'd2: return 4'b0010;
            3'd3: return 4'b0011;
            3'd4: return 4'b0100;
            3'd5: return x.f7 ? 4'b1101 : 4'b0101;
            3'd6: return 4'b0110;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic chk_zero_state(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.ex_valid}, 32'd0);
        chk({tag, "_rw"}, {31'd0, bus.ex_reg_write}, 32'd0);
        chk({tag, "_mr"}, {31'd0, bus.ex_mem_read}, 32'd0);
        chk({tag, "_rd"}, {27'd0, bus.ex_rd}, 32'd0);
        chk({tag, "_op"}, {28'd0, bus.aluop_control}, 32'd0);
        chk({tag, "_op1"}, bus.operand1, 32'd0);
        chk({tag, "_op2"}, bus.operand2, 32'd0);
        chk({tag, "_st"}, bus.ex_store_data, 32'd0);
        chk({tag, "_haz"}, {31'd0, bus.load_use_hazard}, 32'd0);
    endtask

    initial begin
        logic haz;
        int   kind;
        logic [2:0] f3r;

        tbl[0]  = '{"add_exm",   1'b1,1'b0,1'b0,1'b0, 3'd0,1'b0, 5'd5,5'd6,  32'h0,32'h99,32'h22,32'h0,
                    1'b1,5'd5,32'h10, 1'b0,5'd0,32'h0,  4'b0000,32'h10,32'h22,32'h22};
        tbl[1]  = '{"dbl_match", 1'b1,1'b0,1'b0,1'b0, 3'd0,1'b0, 5'd3,5'd7,  32'h0,32'h33,32'h77,32'h0,
                    1'b1,5'd7,32'h1,  1'b1,5'd7,32'h2,  4'b0000,32'h33,32'h1,32'h1};
        tbl[2]  = '{"x0_src",    1'b1,1'b0,1'b0,1'b0, 3'd0,1'b0, 5'd0,5'd0,  32'h0,32'h0,32'h0,32'h0,
                    1'b1,5'd0,32'hFF, 1'b1,5'd0,32'hEE, 4'b0000,32'h0,32'h0,32'h0};
        tbl[3]  = '{"srai",      1'b0,1'b1,1'b0,1'b0, 3'd5,1'b1, 5'd2,5'd0,  32'h0,32'h80000000,32'h0,32'h3,
                    1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  4'b1101,32'h80000000,32'h3,32'h0};
        tbl[4]  = '{"addi_b30",  1'b0,1'b1,1'b0,1'b0, 3'd0,1'b1, 5'd1,5'd0,  32'h0,32'h5,32'h0,32'h40000000,
                    1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  4'b0000,32'h5,32'h40000000,32'h0};
        tbl[5]  = '{"sub_wb",    1'b1,1'b0,1'b0,1'b0, 3'd0,1'b1, 5'd9,5'd10, 32'h0,32'h1,32'h2,32'h0,
                    1'b1,5'd11,32'hCC, 1'b1,5'd10,32'hAB, 4'b1000,32'h1,32'hAB,32'hAB};
        tbl[6]  = '{"lui",       1'b0,1'b1,1'b1,1'b0, 3'd0,1'b0, 5'd5,5'd0,  32'h0,32'h77,32'h0,32'h12345000,
                    1'b1,5'd5,32'h10, 1'b0,5'd0,32'h0,  4'b0000,32'h0,32'h12345000,32'h0};
        tbl[7]  = '{"auipc",     1'b0,1'b1,1'b0,1'b1, 3'd0,1'b0, 5'd0,5'd0,  32'h100,32'h0,32'h0,32'h2000,
                    1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  4'b0000,32'h100,32'h2000,32'h0};
        tbl[8]  = '{"and_nowe",  1'b1,1'b0,1'b0,1'b0, 3'd7,1'b0, 5'd4,5'd6,  32'h0,32'hF0F0,32'h0FF0,32'h0,
                    1'b0,5'd4,32'h66, 1'b0,5'd4,32'h55, 4'b0111,32'hF0F0,32'h0FF0,32'h0FF0};
        tbl[9]  = '{"srli",      1'b0,1'b1,1'b0,1'b0, 3'd5,1'b0, 5'd3,5'd0,  32'h0,32'h8,32'h0,32'h2,
                    1'b1,5'd3,32'h40, 1'b0,5'd0,32'h0,  4'b0101,32'h40,32'h2,32'h0};
        tbl[10] = '{"slti_st",   1'b0,1'b1,1'b0,1'b0, 3'd2,1'b0, 5'd1,5'd2,  32'h0,32'h100,32'h5,32'h8,
                    1'b0,5'd0,32'h0,  1'b1,5'd2,32'h77, 4'b0010,32'h100,32'h8,32'h77};

        // Reset with forwarding idle
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_id(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0, 5'd0,5'd0,5'd0, 32'h0,32'h0,32'h0,32'h0);
        set_fwd(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0);
        tick(); tick();
        chk_zero_state("reset");
        rst = 1'b0;

        // Directed vectors: load, then present forwarding, then compare
        for (int i = 0; i < 11; i++) begin
            set_fwd(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0);
            drive_id(1'b1, tbl[i].rt, tbl[i].si, tbl[i].lui, tbl[i].au, 1'b0, 1'b1,
                     tbl[i].f3, tbl[i].f7, tbl[i].rs1, tbl[i].rs2, 5'd1,
                     tbl[i].pc, tbl[i].d1, tbl[i].d2, tbl[i].imm);
            tick();
            set_fwd(tbl[i].ew, tbl[i].erd, tbl[i].eres, tbl[i].ww, tbl[i].wrd, tbl[i].wres);
            #1;
            chk({tbl[i].nm, "_valid"}, {31'd0, bus.ex_valid}, 32'd1);
            chk({tbl[i].nm, "_op"}, {28'd0, bus.aluop_control}, {28'd0, tbl[i].op});
            chk({tbl[i].nm, "_op1"}, bus.operand1, tbl[i].o1);
            chk({tbl[i].nm, "_op2"}, bus.operand2, tbl[i].o2);
            chk({tbl[i].nm, "_st"}, bus.ex_store_data, tbl[i].st);
        end

        // Load-use: lw x4 in EX, decode reads x4 as rs2
        set_fwd(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0);
        drive_id(1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1, 3'd2,1'b0, 5'd1,5'd0,5'd4, 32'h0,32'h0,32'h0,32'h0);
        tick();
        chk("lu_load_mr", {31'd0, bus.ex_mem_read}, 32'd1);
        drive_id(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 3'd0,1'b0, 5'd1,5'd4,5'd8, 32'h0,32'h10,32'hDEAD,32'h0);
        #1;
        chk("lu_hazard", {31'd0, bus.load_use_hazard}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("lu_bubble_rw", {31'd0, bus.ex_reg_write}, 32'd0);
        chk("lu_hazard_clear", {31'd0, bus.load_use_hazard}, 32'd0);
        set_fwd(1'b0,5'd0,32'h0, 1'b1,5'd4,32'h1234);
        tick();
        chk("lu_reload_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("lu_reload_rd", {27'd0, bus.ex_rd}, 32'd8);
        chk("lu_wb_fwd_op2", bus.operand2, 32'h1234);
        chk("lu_wb_fwd_st", bus.ex_store_data, 32'h1234);

        // Priority: flush beats stall, rst beats stall
        set_fwd(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0);
        drive_id(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 3'd0,1'b0, 5'd2,5'd3,5'd9, 32'h0,32'h1,32'h2,32'h0);
        tick();
        chk("pri_load_valid", {31'd0, bus.ex_valid}, 32'd1);
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("pri_flush_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("pri_flush_rw", {31'd0, bus.ex_reg_write}, 32'd0);
        stall = 1'b0; flush = 1'b0;
        drive_id(1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 3'd0,1'b0, 5'd6,5'd7,5'd12, 32'h40,32'h5,32'h6,32'h9);
        tick();
        chk("pri_load2_rd", {27'd0, bus.ex_rd}, 32'd12);
        stall = 1'b1;
        drive_id(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 3'd1,1'b0, 5'd8,5'd9,5'd13, 32'h80,32'h7,32'h8,32'h0);
        tick();
        chk("pri_stall_rd", {27'd0, bus.ex_rd}, 32'd12);
        chk("pri_stall_op1", bus.operand1, 32'h40);
        rst = 1'b1;
        tick();
        chk_zero_state("pri_rst");
        rst = 1'b0; stall = 1'b0;

        // Randomized traffic against the model
        m = '0;
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            kind  = $urandom_range(0, 3);
            f3r   = 3'($urandom_range(0, 7));
            drive_id(1'($urandom_range(0, 7) != 0), kind == 0, kind != 0, kind == 2, kind == 3,
                     1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                     f3r, (kind == 0) ? ((f3r == 3'd0 || f3r == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0)
                                      : 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     $urandom, $urandom, $urandom, $urandom);
            set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            #1;
            haz = m.v && m.mr && (m.rd != 5'd0)
                  && (m.rd == bus.id_rs1_addr || m.rd == bus.id_rs2_addr);
            chk("rnd_haz", {31'd0, bus.load_use_hazard}, {31'd0, haz});
            chk("rnd_valid", {31'd0, bus.ex_valid}, {31'd0, m.v});
            chk("rnd_rw", {31'd0, bus.ex_reg_write}, {31'd0, m.rw});
            chk("rnd_mr", {31'd0, bus.ex_mem_read}, {31'd0, m.mr});
            if (m.v) begin
                chk("rnd_rd", {27'd0, bus.ex_rd}, {27'd0, m.rd});
                chk("rnd_op", {28'd0, bus.aluop_control}, {28'd0, ref_op(m)});
                chk("rnd_op1", bus.operand1, m.au ? m.pc : (m.lui ? 32'h0 : ref_fwd(m.rs1, m.d1)));
                chk("rnd_op2", bus.operand2, m.si ? m.imm : ref_fwd(m.rs2, m.d2));
                chk("rnd_st", bus.ex_store_data, ref_fwd(m.rs2, m.d2));
            end
            nx = m;
            if (rst) begin
                nx = '0;
            end else if (flush || haz) begin
                nx.v = 1'b0; nx.rw = 1'b0; nx.mr = 1'b0;
            end else if (!stall) begin
                nx.v   = bus.id_valid;
                nx.rw  = bus.id_valid && bus.id_reg_write;
                nx.mr  = bus.id_valid && bus.id_mem_read;
                nx.rd  = bus.id_rd_addr;
                nx.rs1 = bus.id_rs1_addr;
                nx.rs2 = bus.id_rs2_addr;
                nx.f3  = bus.id_funct3;
                nx.f7  = bus.id_funct7_b5;
                nx.rt  = bus.id_is_rtype;
                nx.si  = bus.id_alu_src_imm;
                nx.lui = bus.id_is_lui;
                nx.au  = bus.id_is_auipc;
                nx.pc  = bus.id_pc;
                nx.d1  = bus.id_rs1_data;
                nx.d2  = bus.id_rs2_data;
                nx.imm = bus.id_imm;
            end
            @(posedge clk);
            m = nx;
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
